// File: rtl/dm_load_unit_pkg.sv
// dm_load_unit_pkg: load opcodes, FSM states and byte-enable encodings shared by load/store paths.
package dm_load_unit_pkg;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction
    function automatic logic is_half(input logic [5:0] op);
        return op == OP_LH || op == OP_LHU;
    endfunction
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
        return (op == OP_LW && off != 2'b00) || (is_half(op) && off[0]);
    endfunction
    function automatic logic [3:0] load_be(input logic [5:0] op, input logic [1:0] off);
        return op == OP_LW ? BE_WORD : is_half(op) ? (off[1] ? BE_HI_HALF : BE_LO_HALF) : BE_BYTE0 << off;
    endfunction
endpackage

// File: rtl/dm_load_unit_load_extend.sv
// load_extend: selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extend
    import dm_load_unit_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_byte = i_word[8*i_off +: 8];
    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    assign o_data = (i_op == OP_LB)  ? {{24{w_byte[7]}}, w_byte} :
                    (i_op == OP_LBU) ? {24'b0, w_byte} :
                    (i_op == OP_LH)  ? {{16{w_half[15]}}, w_half} :
                    (i_op == OP_LHU) ? {16'b0, w_half} : i_word;
endmodule

// File: rtl/dm_load_unit.sv
// dm_load_unit: M-stage load path; issues word reads, stalls until ack or timeout, returns extended data to W.
module dm_load_unit
    import dm_load_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_m,
    input  logic [31:0] addr_m,
    input  logic        valid_m,
    input  logic        flush_m,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] load_data_w,
    output logic        load_valid_w,
    output logic        misalign_exc,
    output logic        bus_err
);
    state_t      r_state;
    logic        r_req, r_valid, r_mis, r_berr, r_discard;
    logic [31:0] r_addr, r_data;
    logic [3:0]  r_be;
    logic [5:0]  r_op;
    logic [1:0]  r_off;
    logic [7:0]  r_cnt;
    logic [5:0]  w_op;
    logic        w_load, w_mis, w_issue, w_tmo, w_wait, w_unused;
    logic [31:0] w_ext;

    assign w_op     = instr_m[31:26];
    assign w_unused = ^instr_m[25:0];
    assign w_load   = valid_m && !flush_m && is_load(w_op);
    assign w_mis    = w_load && is_misaligned(w_op, addr_m[1:0]);
    assign w_issue  = w_load && !w_mis;
    assign w_wait   = r_state == S_WAIT;
    assign w_tmo    = r_cnt == 8'(TIMEOUT - 1) && !mem_ack;
    // Releasing stall on ack lets the load leave M on the same edge its data is captured.
    assign stall = !reset && ((!w_wait && w_issue) || (w_wait && !mem_ack && !w_tmo));

    assign mem_req      = r_req;
    assign mem_addr     = r_addr;
    assign mem_be       = r_be;
    assign load_data_w  = r_data;
    assign load_valid_w = r_valid;
    assign misalign_exc = r_mis;
    assign bus_err      = r_berr;

    load_extend u_ext (.i_op(r_op), .i_off(r_off), .i_word(mem_rdata), .o_data(w_ext));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_op      <= '0;
            r_off     <= '0;
            r_cnt     <= '0;
            r_discard <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_mis     <= 1'b0;
            r_berr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_berr  <= 1'b0;
            if (!w_wait) begin
                if (w_mis) begin
                    r_mis <= 1'b1;
                end else if (w_issue) begin
                    r_state   <= S_WAIT;
                    r_req     <= 1'b1;
                    r_addr    <= {addr_m[31:2], 2'b00};
                    r_be      <= load_be(w_op, addr_m[1:0]);
                    r_op      <= w_op;
                    r_off     <= addr_m[1:0];
                    r_cnt     <= '0;
                    r_discard <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + 8'd1;
                if (flush_m) r_discard <= 1'b1;
                if (mem_ack) begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    if (!r_discard && !flush_m) begin
                        r_data  <= w_ext;
                        r_valid <= 1'b1;
                    end
                end else if (w_tmo) begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_berr  <= 1'b1;
                    r_data  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_load_unit.sv
// tb_dm_load_unit: directed loads with a transaction-level model checked every cycle plus literal expectations.
module tb_dm_load_unit;
    localparam int TMO = 4;
    localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001, LHU = 6'b100101, LW = 6'b100011;

    logic        clk = 0, reset = 1, valid_m = 0, flush_m = 0, mem_ack = 0;
    logic [31:0] instr_m = 0, addr_m = 0, mem_rdata = 0;
    logic        mem_req, stall, load_valid_w, misalign_exc, bus_err;
    logic [31:0] mem_addr, load_data_w;
    logic [3:0]  mem_be;

    int ntest = 0, nfail = 0, nst = 0;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;

    dm_load_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .instr_m(instr_m), .addr_m(addr_m), .valid_m(valid_m),
        .flush_m(flush_m), .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .load_data_w(load_data_w),
        .load_valid_w(load_valid_w), .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic bit m_is_load(input logic [5:0] op);
        return op == LB || op == LBU || op == LH || op == LHU || op == LW;
    endfunction
    function automatic bit m_misal(input logic [5:0] op, input logic [31:0] a);
        return (op == LW && a % 4 != 0) || ((op == LH || op == LHU) && a % 2 != 0);
    endfunction
    function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
        if (op == LW) return 4'hF;
        if (op == LH || op == LHU) return (a % 4 >= 2) ? 4'hC : 4'h3;
        return 4'(1 << (a % 4));
    endfunction
    function automatic logic [31:0] m_extract(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (a % 4 >= 2) ? (w >> 16) : (w & 32'hFFFF);
        if (op == LB)  return (b >= 128) ? b - 256 : b;
        if (op == LBU) return b;
        if (op == LH)  return (h >= 32768) ? h - 65536 : h;
        if (op == LHU) return h;
        return w;
    endfunction

    // Transaction model: one pending load, how long it has waited, and whether it was flushed.
    bit          busy = 0, drop = 0;
    int          waited = 0;
    logic [5:0]  p_op;
    logic [31:0] p_addr;
    bit          e_valid = 0, e_mis = 0, e_berr = 0;
    logic [31:0] e_data = 0;

    always @(negedge clk) begin
        bit det;
        if (reset) begin
            busy = 0; drop = 0; waited = 0;
            e_valid = 0; e_mis = 0; e_berr = 0; e_data = 0;
            chk("rst_stall", stall, 0);
            chk("rst_req", mem_req, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_be", mem_be, 0);
        end else begin
            det = valid_m && !flush_m && m_is_load(instr_m[31:26]);
            chk("stall", stall, busy ? !(mem_ack || waited == TMO - 1) : det && !m_misal(instr_m[31:26], addr_m));
            chk("req", mem_req, busy);
            if (busy) begin
                chk("addr", mem_addr, p_addr & ~32'h3);
                chk("be", mem_be, m_be(p_op, p_addr));
            end
        end
        chk("valid", load_valid_w, e_valid);
        chk("data", load_data_w, e_data);
        chk("mis", misalign_exc, e_mis);
        chk("berr", bus_err, e_berr);
        if (!reset) begin
            e_valid = 0; e_mis = 0; e_berr = 0;
            if (busy) begin
                if (mem_ack) begin
                    busy = 0;
                    if (!drop && !flush_m) begin
                        e_valid = 1;
                        e_data = m_extract(p_op, p_addr, mem_rdata);
                    end
                end else if (waited == TMO - 1) begin
                    busy = 0; e_berr = 1; e_data = 0;
                end else begin
                    waited++;
                    if (flush_m) drop = 1;
                end
            end else if (det) begin
                if (m_misal(instr_m[31:26], addr_m)) e_mis = 1;
                else begin
                    busy = 1; waited = 0; drop = 0; p_op = instr_m[31:26]; p_addr = addr_m;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (stall) nst++;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] op, input logic [31:0] a, input int nw, input logic [31:0] rd);
        nst = 0;
        instr_m = {op, 26'h0}; addr_m = a; valid_m = 1;
        tick();
        cap_addr = mem_addr; cap_be = mem_be;
        repeat (nw) tick();
        mem_ack = 1; mem_rdata = rd;
        tick();
        mem_ack = 0; valid_m = 0; instr_m = 0;
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_data", load_data_w, 0);
        reset = 0;
        tick();
        load(LB, 32'h1003, 3, 32'h80FF_0000);
        chk("lb_data", load_data_w, 32'hFFFF_FF80);
        chk("lb_valid", load_valid_w, 1);
        chk("lb_addr", cap_addr, 32'h1000);
        chk("lb_be", cap_be, 4'b1000);
        chk("lb_stall_cycles", nst, 4);
        tick();
        chk("lb_pulse_once", load_valid_w, 0);
        load(LHU, 32'h2002, 0, 32'h8001_1234);
        chk("lhu_data", load_data_w, 32'h0000_8001);
        chk("lhu_be", cap_be, 4'b1100);
        chk("lhu_stall_cycles", nst, 1);
        load(LH, 32'h2002, 0, 32'h8001_1234);
        chk("lh_data", load_data_w, 32'hFFFF_8001);
        nst = 0;
        instr_m = {LW, 26'h0}; addr_m = 32'h3001; valid_m = 1;
        tick();
        chk("lw_mis", misalign_exc, 1);
        chk("lw_mis_req", mem_req, 0);
        instr_m = {LH, 26'h0}; addr_m = 32'h3003;
        tick();
        chk("lh_mis", misalign_exc, 1);
        valid_m = 0;
        tick();
        chk("mis_pulse_end", misalign_exc, 0);
        chk("mis_no_stall", nst, 0);
        nst = 0;
        instr_m = {LW, 26'h0}; addr_m = 32'h4000; valid_m = 1;
        repeat (5) tick();
        valid_m = 0;
        chk("tmo_berr", bus_err, 1);
        chk("tmo_data", load_data_w, 0);
        chk("tmo_valid", load_valid_w, 0);
        chk("tmo_stall_cycles", nst, 4);
        chk("tmo_idle", mem_req, 0);
        load(LW, 32'h4004, 3, 32'h1234_5678);
        chk("ack_at_limit_data", load_data_w, 32'h1234_5678);
        chk("ack_at_limit_berr", bus_err, 0);
        instr_m = {LW, 26'h0}; addr_m = 32'h5000; valid_m = 1;
        tick();
        flush_m = 1;
        tick();
        flush_m = 0;
        tick();
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 0; valid_m = 0;
        chk("flush_valid", load_valid_w, 0);
        chk("flush_data", load_data_w, 32'h1234_5678);
        load(LBU, 32'h10, 1, 32'h0000_00A5);
        chk("lbu_after_flush", load_data_w, 32'h0000_00A5);
        chk("lbu_stall_cycles", nst, 2);
        mem_ack = 1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 0;
        chk("idle_ack_ignored", load_valid_w, 0);
        instr_m = {LW, 26'h0}; addr_m = 32'h6000; valid_m = 1;
        repeat (2) tick();
        reset = 1;
        #1;
        chk("midwait_rst_req", mem_req, 0);
        chk("midwait_rst_stall", stall, 0);
        chk("midwait_rst_data", load_data_w, 0);
        valid_m = 0;
        tick();
        reset = 0;
        tick();
        chk("post_rst_no_pulse", load_valid_w | bus_err | misalign_exc, 0);
        load(LW, 32'h6008, 2, 32'hCAFE_F00D);
        chk("post_rst_lw", load_data_w, 32'hCAFE_F00D);
        tick();
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule

// File: doc/dm_load_unit.md
Name: dm_load_unit

Overview:
- Read-side counterpart of the M-stage store byte-enable/write-data path in the pipelined MIPS core.
- Issues word reads to a variable-latency data memory for loads in the M stage, and stalls the pipeline until the memory acknowledges.
- Extracts the addressed byte or halfword from the returned word and sign- or zero-extends it.
- Presents a registered result to the W stage; also detects misaligned loads and memory timeouts.

Parameters:
- TIMEOUT, 255: max cycles in WAIT before abort; range 1..255, counter is 8 bits.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- instr_m  in  32  Instruction in M stage; opcode is instr_m[31:26].
- addr_m  in  32  Effective address (ALU output) in M.
- valid_m  in  1  M-stage instruction is valid (not a bubble).
- flush_m  in  1  Kill the M-stage instruction.
- mem_req  out  1  Read request, held high until acknowledged.
- mem_addr  out  32  Word address: addr_m with [1:0] forced to 0.
- mem_be  out  4  Byte lanes being read.
- mem_ack  in  1  Memory returns data this cycle.
- mem_rdata  in  32  Returned word; valid only when mem_ack=1.
- stall  out  1  Freeze F/D/E/M pipeline registers.
- load_data_w  out  32  Extended load result for W.
- load_valid_w  out  1  One-cycle pulse: load_data_w is valid.
- misalign_exc  out  1  One-cycle pulse: misaligned load.
- bus_err  out  1  One-cycle pulse: memory timeout.

Behaviour:
- Decode, on opcode instr_m[31:26]: LB 100000, LBU 100100, LH 100001, LHU 100101, LW 100011. A load is detected when valid_m=1, flush_m=0 and the opcode is one of these.
- Misalignment:
  - LW with addr_m[1:0]!=0.
  - LH/LHU with addr_m[0]=1.
  - Byte loads are never misaligned.
- FSM states: IDLE, WAIT.
- IDLE, aligned load detected:
  - Register mem_addr, mem_be, opcode and addr_m[1:0].
  - Clear the timeout counter.
  - Go to WAIT.
  - stall=1 combinationally in this cycle.
- IDLE, misaligned load detected:
  - Next cycle, misalign_exc=1.
  - No request, no stall, load_valid_w=0.
- WAIT:
  - mem_req=1 and stall=1.
  - Counter increments each cycle.
- WAIT with mem_ack=1:
  - stall=0 this cycle, so the M instruction advances at the same edge.
  - At that edge, load_data_w is captured and load_valid_w=1 for one cycle; go to IDLE.
- WAIT with no ack for TIMEOUT cycles, i.e. counter==TIMEOUT-1 and mem_ack=0:
  - stall=0; next cycle bus_err=1, load_data_w=0, load_valid_w=0.
  - Go to IDLE.
- mem_ack in the same cycle as a timeout: the ack wins.
- mem_ack while in IDLE is ignored.
- mem_be encoding, same as the store side:
  - LW: 1111.
  - LH/LHU: 0011 if addr[1]=0, else 1100.
  - LB/LBU: one-hot 0001/0010/0100/1000 for addr[1:0]=0/1/2/3.
- Extraction (off = latched addr[1:0]):
  - Byte: mem_rdata[8*off+7 : 8*off].
  - Half: mem_rdata[31:16] if off[1]=1, else mem_rdata[15:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- flush_m while in WAIT:
  - Set a discard flag and keep waiting; stall stays high, so outstanding requests never overlap.
  - On ack, return to IDLE with load_valid_w=0 and load_data_w unchanged.
- Back-to-back loads: a load in M in the cycle after returning to IDLE issues immediately.
- Reset values, asynchronous:
  - state=IDLE.
  - mem_req=0, mem_addr=0, mem_be=0.
  - load_data_w=0, load_valid_w=0.
  - misalign_exc=0, bus_err=0.
  - Counter=0, discard=0.
- Reset mid-WAIT aborts the request and emits no pulse.
- stall=0 while reset is asserted.

Decomposition:
- Shared package: load opcode constants (LB, LBU, LH, LHU, LW), FSM state encodings, BE encodings.
- The store-side decode already uses these opcode values; both blocks take them from the package.
- One sub-module: load_extend. Purely combinational: opcode, offset and word in, 32-bit extended value out.

Test Plan:
- LB, addr 0x0000_1003, ack after 3 cycles, rdata 0x80FF_0000 -> mem_be=1000, mem_addr=0x1000, stall high for 4 cycles, load_data_w=0xFFFF_FF80, one load_valid_w pulse.
- LHU, addr 0x2002, ack on the first WAIT cycle, rdata 0x8001_1234 -> mem_be=1100, load_data_w=0x0000_8001; LH at the same address -> 0xFFFF_8001.
- LW, addr 0x3001 -> misalign_exc pulse, mem_req never high, stall=0; LH at 0x3003 -> same response.
- LW, TIMEOUT=4, no ack -> stall high for 4 cycles, then bus_err pulse, load_data_w=0, state IDLE; then ack at exactly cycle 4 -> data accepted, no bus_err.
- LW, flush_m=1 in the first WAIT cycle, ack after 2 cycles with rdata 0xDEAD_BEEF -> load_valid_w stays 0, load_data_w unchanged; a following LBU at 0x10 issues on the next cycle.
- reset asserted mid-WAIT -> all outputs 0 immediately; after release, an LW with ack returns normally.
